// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: tracks DEPTH in-flight writers, picks forwarding sources, raises load-use stall.
// Optional HAZ_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
   parameter int REG_AW            = 5,
   parameter int DEPTH             = 3,
   parameter int LOAD_STALL_STAGES = 1,
   parameter int FW                = $clog2(DEPTH + 1)
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_d,
   input  logic              id_wreg,
   input  logic              id_m2reg,
   input  logic              flush,
   output logic              stall,
   output logic [FW-1:0]     fwda,
   output logic [FW-1:0]     fwdb,
   output logic [DEPTH-1:0]  slot_valid
`ifdef HAZ_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   // Bit k-1 of each vector describes slot k (slot 1 = EXE).
   logic [DEPTH-1:0]             wreg_q, wreg_d;
   logic [DEPTH-1:0]             m2reg_q, m2reg_d;
   logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
   logic [DEPTH-1:0]             match_a, match_b;
   logic                         hazard;
   logic                         accept;

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      match_a = '0;
      match_b = '0;
      hazard  = 1'b0;
      fwda    = '0;
      fwdb    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match_a[k] = wreg_q[k] && id_use_rs && (id_rs != '0) && (dst_q[k] == id_rs);
         match_b[k] = wreg_q[k] && id_use_rt && (id_rt != '0) && (dst_q[k] == id_rt);
      end
      // Scan oldest to youngest so the youngest producer is written last and wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (match_a[k]) fwda = FW'(k + 1);
         if (match_b[k]) fwdb = FW'(k + 1);
      end
      for (int k = 0; k < LOAD_STALL_STAGES; k++) begin
         if (m2reg_q[k] && (match_a[k] || match_b[k])) hazard = 1'b1;
      end
      stall  = hazard && !flush;
      accept = !stall && !flush;
   end

   always_comb begin
      wreg_d  = {wreg_q[DEPTH-2:0],  id_wreg  && accept};
      m2reg_d = {m2reg_q[DEPTH-2:0], id_m2reg && accept};
      dst_d   = {dst_q[DEPTH-2:0],   accept ? id_d : {REG_AW{1'b0}}};
   end

   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignment; the slot file is a
      // handful of flops, so it clears on reset like any other register.
      if (!Resetn) begin
         wreg_q  <= '0;
         m2reg_q <= '0;
         dst_q   <= '0;
      end else begin
         wreg_q  <= wreg_d;
         m2reg_q <= m2reg_d;
         dst_q   <= dst_d;
      end
   end

   assign slot_valid = wreg_q;

`ifdef HAZ_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (L=1, L=2) on shared stimulus, each against a record-list model.
// Counter checks are compiled in when HAZ_STATS_EN is defined.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, id_d;
   logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;

   logic       stall1, stall2;
   logic [1:0] fwda1, fwdb1, fwda2, fwdb2;
   logic [2:0] valid1, valid2;
`ifdef HAZ_STATS_EN
   logic [31:0] sc1, fc1, sc2, fc2;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_STALL_STAGES(1)) u_l1 (
      .Clock(clk), .Resetn(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_d(id_d), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
      .stall(stall1), .fwda(fwda1), .fwdb(fwdb1), .slot_valid(valid1)
`ifdef HAZ_STATS_EN
      , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
   );

   pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_STALL_STAGES(2)) u_l2 (
      .Clock(clk), .Resetn(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_d(id_d), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
      .stall(stall2), .fwda(fwda2), .fwdb(fwdb2), .slot_valid(valid2)
`ifdef HAZ_STATS_EN
      , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: per instance, a list of in-flight instruction records, index 0 = youngest (EXE).
   typedef struct {
      logic [4:0] d;
      bit         w;
      bit         ld;
   } rec_t;

   rec_t m[2][3];
   int   m_stalls[2];
   int   m_flushes;
   bit   model_valid = 1'b0;

   function automatic bit reads(rec_t r, logic [4:0] src, logic used);
      return used && r.w && (src != 5'd0) && (r.d == src);
   endfunction

   function automatic int exp_fwd(int i, logic [4:0] src, logic used);
      for (int k = 0; k < 3; k++)
         if (reads(m[i][k], src, used)) return k + 1;
      return 0;
   endfunction

   // Instance i has a load-latency window of i+1 stages.
   function automatic bit exp_stall(int i);
      bit hz = 1'b0;
      for (int k = 0; k <= i; k++)
         if (m[i][k].ld && (reads(m[i][k], id_rs, id_use_rs) || reads(m[i][k], id_rt, id_use_rt)))
            hz = 1'b1;
      return hz && !flush;
   endfunction

   function automatic logic [2:0] exp_valid(int i);
      return {m[i][2].w, m[i][1].w, m[i][0].w};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            for (int k = 0; k < 3; k++) m[i][k] <= '{d: 5'd0, w: 1'b0, ld: 1'b0};
            m_stalls[i] <= 0;
         end else begin
            m[i][2] <= m[i][1];
            m[i][1] <= m[i][0];
            if (!exp_stall(i) && !flush) m[i][0] <= '{d: id_d, w: id_wreg, ld: id_m2reg};
            else                         m[i][0] <= '{d: 5'd0, w: 1'b0, ld: 1'b0};
            if (exp_stall(i)) m_stalls[i] <= m_stalls[i] + 1;
         end
      end
      if (!rst_n)     m_flushes <= 0;
      else if (flush) m_flushes <= m_flushes + 1;
      if (!rst_n) model_valid <= 1'b1;
   end

   task automatic cmp(input int i, input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [2:0] sv);
      bit es;
      es = exp_stall(i);
      check($sformatf("L%0d stall", i + 1), 32'(st), 32'(es));
      check($sformatf("L%0d slot_valid", i + 1), 32'(sv), 32'(exp_valid(i)));
      if (!es) begin
         check($sformatf("L%0d fwda", i + 1), 32'(fa), 32'(exp_fwd(i, id_rs, id_use_rs)));
         check($sformatf("L%0d fwdb", i + 1), 32'(fb), 32'(exp_fwd(i, id_rt, id_use_rt)));
      end
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         cmp(0, stall1, fwda1, fwdb1, valid1);
         cmp(1, stall2, fwda2, fwdb2, valid2);
`ifdef HAZ_STATS_EN
         check("L1 stall_cnt", sc1, 32'(m_stalls[0]));
         check("L2 stall_cnt", sc2, 32'(m_stalls[1]));
         check("L1 flush_cnt", fc1, 32'(m_flushes));
         check("L2 flush_cnt", fc2, 32'(m_flushes));
`endif
      end
   end

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [4:0] d, input logic w, input logic ld, input logic fl);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_d = d; id_wreg = w; id_m2reg = ld; flush = fl;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) nxt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held two edges with a writer presented in ID.
      rst_n = 1'b0;
      drive(7, 0, 1, 0, 7, 1, 0, 0);
      smp();
      check("rst stall", 32'(stall1), 0);
      check("rst fwda", 32'(fwda1), 0);
      check("rst valid", 32'(valid1), 0);
      nxt();
      rst_n = 1'b1;
      drive(7, 0, 1, 0, 0, 0, 0, 0);
      smp();
      check("post-rst stall", 32'(stall2), 0);
      check("post-rst fwda", 32'(fwda1), 0);
      check("post-rst fwdb", 32'(fwdb1), 0);
      check("post-rst valid", 32'(valid2), 0);
      nxt();

      // ALU chain: r3 walks through slots 1..3.
      drive(0, 0, 0, 0, 3, 1, 0, 0); nxt();
      drive(3, 0, 1, 0, 0, 0, 0, 0);
      smp(); check("chain fwda=1", 32'(fwda1), 1); check("chain valid 001", 32'(valid1), 3'b001); nxt();
      smp(); check("chain fwda=2", 32'(fwda2), 2); check("chain valid 010", 32'(valid1), 3'b010); nxt();
      smp(); check("chain fwda=3", 32'(fwda1), 3); check("chain valid 100", 32'(valid1), 3'b100); nxt();
      smp(); check("chain fwda=0", 32'(fwda1), 0); nxt();

      // Youngest producer wins.
      drive(0, 0, 0, 0, 5, 1, 0, 0); nxt();
      drive(5, 0, 1, 0, 5, 1, 0, 0); smp(); check("young fwda slot1", 32'(fwda1), 1); nxt();
      drive(5, 0, 1, 0, 0, 0, 0, 0); smp();
      check("young fwda 1 not 2", 32'(fwda1), 1);
      check("young valid 011", 32'(valid2), 3'b011);
      nxt();
      idle(3);

      // Load-use: L=1 stalls one cycle then forwards from slot 2; L=2 stalls two, then slot 3.
      drive(0, 0, 0, 0, 4, 1, 1, 0); nxt();
      drive(0, 4, 0, 1, 9, 1, 0, 0);
      smp(); check("lu L1 stall c1", 32'(stall1), 1); check("lu L2 stall c1", 32'(stall2), 1); nxt();
      smp();
      check("lu L1 stall c2", 32'(stall1), 0);
      check("lu L1 fwdb=2", 32'(fwdb1), 2);
      check("lu L1 bubble valid", 32'(valid1), 3'b010);
      check("lu L2 stall c2", 32'(stall2), 1);
      nxt();
      smp(); check("lu L2 stall c3", 32'(stall2), 0); check("lu L2 fwdb=3", 32'(fwdb2), 3); nxt();
      idle(3);

      // r0 never matches; an unused source never stalls.
      drive(0, 0, 0, 0, 0, 1, 0, 0); nxt();
      drive(0, 0, 1, 0, 0, 0, 0, 0); smp();
      check("r0 fwda", 32'(fwda1), 0); check("r0 stall", 32'(stall1), 0); nxt();
      drive(0, 0, 0, 0, 6, 1, 1, 0); nxt();
      drive(6, 0, 0, 0, 0, 0, 0, 0); smp();
      check("unused L1 stall", 32'(stall1), 0); check("unused L2 stall", 32'(stall2), 0); nxt();
      idle(3);

      // Flush beats a load-use stall in the same cycle.
      drive(0, 0, 0, 0, 4, 1, 1, 0); nxt();
      drive(0, 4, 0, 1, 8, 1, 0, 1); smp();
      check("flush L1 stall", 32'(stall1), 0); check("flush L2 stall", 32'(stall2), 0); nxt();
      drive(0, 0, 0, 0, 0, 0, 0, 0); smp();
      check("flush bubble L1", 32'(valid1), 3'b010);
      check("flush bubble L2", 32'(valid2), 3'b010);
`ifdef HAZ_STATS_EN
      check("flush_cnt L1", fc1, 32'd1);
      check("stall_cnt L1", sc1, 32'd1);
      check("stall_cnt L2", sc2, 32'd2);
`endif
      nxt();

      // Reset in the middle of a stall.
      drive(0, 0, 0, 0, 2, 1, 1, 0); nxt();
      drive(2, 0, 1, 0, 0, 0, 0, 0); smp();
      check("midrst stall before", 32'(stall1), 1);
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
      smp();
      check("midrst L1 stall", 32'(stall1), 0);
      check("midrst L2 stall", 32'(stall2), 0);
      check("midrst valid", 32'(valid1), 0);
`ifdef HAZ_STATS_EN
      check("midrst stall_cnt", sc1, 32'd0);
`endif
      nxt();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
